// File: rtl/spatz_cluster_barrier.sv
// Hardware barrier for the Spatz cluster: gathers core arrivals
// over a participation mask and releases them together.
module spatz_cluster_barrier #(
  parameter int unsigned NrCores       = 4,
  parameter int unsigned TimeoutCycles = 0,
  parameter int unsigned CntWidth      = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NrCores-1:0]  barrier_mask_i,
  input  logic [NrCores-1:0]  req_valid_i,
  output logic [NrCores-1:0]  req_ready_o,
  output logic [NrCores-1:0]  rsp_valid_o,
  output logic                busy_o,
  output logic                timeout_o,
  output logic [CntWidth-1:0] generation_o,
  output logic [NrCores-1:0]  stall_o
);

  localparam logic [1:0] Idle    = 2'd0;
  localparam logic [1:0] Gather  = 2'd1;
  localparam logic [1:0] Release = 2'd2;

  localparam logic [CntWidth-1:0] TmoLast =
    CntWidth'(TimeoutCycles - 1);

  logic [1:0]          state_q, state_d;
  logic [NrCores-1:0]  arrived_q, arrived_d;
  logic [NrCores-1:0]  mask_q, mask_d;
  logic [NrCores-1:0]  self_q, self_d;
  logic [NrCores-1:0]  accepted, mask_eff;
  logic [CntWidth-1:0] gen_q, tmo_q, tmo_d;
  logic                flag_q, flag_d;
  logic                in_rel, covered, tmo_hit;

  assign in_rel = (state_q == Release);

  // Handshake and output decode
  assign req_ready_o  = in_rel ? '0 : ~arrived_q;
  assign accepted     = req_valid_i & req_ready_o;
  assign rsp_valid_o  = self_q | (in_rel ? arrived_q : '0);
  assign busy_o       = (state_q != Idle);
  assign timeout_o    = in_rel & flag_q;
  assign generation_o = gen_q;
  assign stall_o      = in_rel ? '0 : arrived_q;

  // The mask is live in IDLE and frozen for the rest of a generation
  assign mask_eff = (state_q == Idle) ? barrier_mask_i : mask_q;
  assign self_d   = accepted & ~mask_eff;
  assign covered  =
    (((arrived_q | accepted) & mask_eff) == mask_eff);
  assign tmo_hit  = (TimeoutCycles != 0) && (tmo_q == TmoLast);

  // Next-state logic for arrivals, timeout and FSM
  always_comb begin
    state_d   = state_q;
    arrived_d = arrived_q;
    mask_d    = mask_q;
    tmo_d     = tmo_q;
    flag_d    = flag_q;
    case (state_q)
      Idle: begin
        if (|accepted) begin
          mask_d    = barrier_mask_i;
          arrived_d = arrived_q | (accepted & barrier_mask_i);
          if (barrier_mask_i != '0)
            state_d = covered ? Release : Gather;
        end
      end
      Gather: begin
        arrived_d = arrived_q | (accepted & mask_q);
        if (!(&tmo_q))
          tmo_d = tmo_q + 1'b1;
        if (covered) begin
          state_d = Release;
        end else if (tmo_hit) begin
          state_d = Release;
          flag_d  = 1'b1;
        end
      end
      Release: begin
        arrived_d = '0;
        tmo_d     = '0;
        flag_d    = 1'b0;
        state_d   = Idle;
      end
      default: begin
        state_d = Idle;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= Idle;
      arrived_q <= '0;
      mask_q    <= '0;
      self_q    <= '0;
      gen_q     <= '0;
      tmo_q     <= '0;
      flag_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      arrived_q <= arrived_d;
      mask_q    <= mask_d;
      self_q    <= self_d;
      tmo_q     <= tmo_d;
      flag_q    <= flag_d;
      if (in_rel)
        gen_q <= gen_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_spatz_cluster_barrier.sv
// Directed table-driven bench for spatz_cluster_barrier
// (4 cores, 8-cycle timeout, 4-bit counters).
module tb_spatz_cluster_barrier;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] mask, req;
  logic [3:0] rdy, rsp, stall, gen;
  logic       busy, tmo;

  int checks   = 0;
  int failures = 0;

  spatz_cluster_barrier #(
    .NrCores(4),
    .TimeoutCycles(8),
    .CntWidth(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .barrier_mask_i(mask),
    .req_valid_i(req),
    .req_ready_o(rdy),
    .rsp_valid_o(rsp),
    .busy_o(busy),
    .timeout_o(tmo),
    .generation_o(gen),
    .stall_o(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] mask;
    logic [3:0] req;
    bit         chk;
    logic [3:0] rdy;
    logic [3:0] rsp;
    logic [3:0] stall;
    logic       busy;
    logic       tmo;
    logic [3:0] gen;
  } vec_t;

  vec_t tv[$];

  function automatic void add(
    logic r, logic [3:0] m, logic [3:0] q, bit c,
    logic [3:0] er, logic [3:0] es, logic [3:0] st,
    logic eb, logic et, logic [3:0] eg);
    vec_t v;
    v.rst = r; v.mask = m; v.req = q; v.chk = c;
    v.rdy = er; v.rsp = es; v.stall = st;
    v.busy = eb; v.tmo = et; v.gen = eg;
    tv.push_back(v);
  endfunction

  task automatic check(string name, int row,
                       logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h exp=%h",
               name, row, act, exp);
    end
  endtask

  task automatic check_all(int row, logic [3:0] er,
    logic [3:0] es, logic [3:0] st, logic eb,
    logic et, logic [3:0] eg);
    check("ready", row, 32'(rdy), 32'(er));
    check("rsp", row, 32'(rsp), 32'(es));
    check("stall", row, 32'(stall), 32'(st));
    check("busy", row, 32'(busy), 32'(eb));
    check("timeout", row, 32'(tmo), 32'(et));
    check("gen", row, 32'(gen), 32'(eg));
  endtask

  initial begin
    logic [3:0] g;
    rst = 1'b1; mask = '0; req = '0;

    // reset
    add(1, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    // staggered arrival, full mask
    add(0, 4'hF, 4'h7, 1, 4'hF, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(0, 4'hF, 4'h0, 1, 4'h8, 0, 4'h7, 1, 0, 0);
    add(0, 4'hF, 4'h8, 1, 4'h8, 0, 4'h7, 1, 0, 0);
    add(0, 4'hF, 4'h0, 1, 4'h0, 4'hF, 0, 1, 0, 0);
    add(0, 4'hF, 4'h0, 1, 4'hF, 0, 0, 0, 0, 1);
    // partial mask with self-release
    add(0, 4'h5, 4'h3, 1, 4'hF, 0, 0, 0, 0, 1);
    add(0, 4'h5, 4'h0, 1, 4'hE, 4'h2, 4'h1, 1, 0, 1);
    add(0, 4'h5, 4'h0, 1, 4'hE, 0, 4'h1, 1, 0, 1);
    add(0, 4'h5, 4'h4, 1, 4'hE, 0, 4'h1, 1, 0, 1);
    add(0, 4'h5, 4'h0, 1, 4'h0, 4'h5, 0, 1, 0, 1);
    add(0, 4'hF, 4'h0, 1, 4'hF, 0, 0, 0, 0, 2);
    // held request, mask change mid-gather
    add(0, 4'hF, 4'h4, 1, 4'hF, 0, 0, 0, 0, 2);
    add(0, 4'h4, 4'h4, 1, 4'hB, 0, 4'h4, 1, 0, 2);
    add(0, 4'h0, 4'h7, 1, 4'hB, 0, 4'h4, 1, 0, 2);
    add(0, 4'h0, 4'hC, 1, 4'h8, 0, 4'h7, 1, 0, 2);
    add(0, 4'hF, 4'h4, 1, 4'h0, 4'hF, 0, 1, 0, 2);
    add(0, 4'hF, 4'h4, 1, 4'hF, 0, 0, 0, 0, 3);
    // reset with 3 of 4 arrived
    add(0, 4'hF, 4'h3, 1, 4'hB, 0, 4'h4, 1, 0, 3);
    add(1, 4'hF, 4'h0, 1, 4'h8, 0, 4'h7, 1, 0, 3);
    add(0, 4'hF, 4'h0, 1, 4'hF, 0, 0, 0, 0, 0);
    add(0, 4'hF, 4'h0, 1, 4'hF, 0, 0, 0, 0, 0);
    // timeout after 8 gather cycles
    add(0, 4'hF, 4'h1, 1, 4'hF, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 4'hF, 4'h0, 1, 4'hE, 0, 4'h1, 1, 0, 0);
    add(0, 4'hF, 4'h0, 1, 4'h0, 4'h1, 0, 1, 1, 0);
    add(0, 4'hF, 4'h0, 1, 4'hF, 0, 0, 0, 0, 1);
    // completion coincides with timeout
    add(0, 4'hF, 4'h1, 1, 4'hF, 0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++)
      add(0, 4'hF, 4'h0, 1, 4'hE, 0, 4'h1, 1, 0, 1);
    add(0, 4'hF, 4'hE, 1, 4'hE, 0, 4'h1, 1, 0, 1);
    add(0, 4'hF, 4'h0, 1, 4'h0, 4'hF, 0, 1, 0, 1);
    // zero mask: all requesters self-release
    add(0, 4'h0, 4'hA, 1, 4'hF, 0, 0, 0, 0, 2);
    add(0, 4'h0, 4'h0, 1, 4'hF, 4'hA, 0, 0, 0, 2);
    add(0, 4'h0, 4'h0, 1, 4'hF, 0, 0, 0, 0, 2);

    @(posedge clk); #1;
    foreach (tv[i]) begin
      rst = tv[i].rst; mask = tv[i].mask; req = tv[i].req;
      @(negedge clk);
      if (tv[i].chk)
        check_all(i, tv[i].rdy, tv[i].rsp, tv[i].stall,
                  tv[i].busy, tv[i].tmo, tv[i].gen);
      @(posedge clk); #1;
    end

    // single-participant barriers until generation wraps
    g = 4'd2;
    for (int k = 0; k < 16; k++) begin
      mask = 4'h1; req = 4'h1;
      @(negedge clk);
      check_all(100 + 2 * k, 4'hF, 0, 0, 0, 0, g);
      @(posedge clk); #1;
      req = 4'h0;
      @(negedge clk);
      check_all(101 + 2 * k, 4'h0, 4'h1, 0, 1, 0, g);
      @(posedge clk); #1;
      g = g + 4'd1;
    end
    @(negedge clk);
    check_all(200, 4'hF, 0, 0, 0, 0, g);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/spatz_cluster_barrier.md
Name: spatz_cluster_barrier

Overview:
Hardware barrier controller for the Spatz cluster. It gathers barrier arrivals from the cores of a participation mask and releases all waiting cores in one cycle once every participant has arrived. It sits beside the cluster peripheral, whose hw_barrier register always reads 0 because the barrier itself lives here. It also produces per-core stall events for the performance counters, a generation counter, and a timeout escape.

Parameters:
NrCores, 4, number of cores (1..32).
TimeoutCycles, 0, GATHER cycles before forced release; 0 disables the timeout.
CntWidth, 32, width of the generation counter and the timeout counter.

Ports:
clk_i  in  1  clock; all logic on the rising edge.
rst_i  in  1  synchronous, active-high reset.
barrier_mask_i  in  NrCores  participating cores; sampled at the first accepted arrival of a generation.
req_valid_i  in  NrCores  per-core arrival request.
req_ready_o  out  NrCores  per-core arrival accept.
rsp_valid_o  out  NrCores  per-core release pulse, one cycle wide.
busy_o  out  1  high when the state is not IDLE.
timeout_o  out  1  one-cycle pulse when a forced release occurs.
generation_o  out  CntWidth  number of completed releases, including timeouts.
stall_o  out  NrCores  core has arrived and is not yet released (perf event).

Behaviour:
- Reset, when rst_i is high at a clock edge:
  - state=IDLE; arrived_q=0, mask_q=0, gen_q=0, tmo_cnt=0.
  - All outputs 0 except req_ready_o, which reads all-ones in IDLE.
  - Reset mid-GATHER discards all arrivals; no rsp_valid_o pulse is issued.
- Arrival acceptance:
  - Core i is accepted when req_valid_i[i] & req_ready_o[i].
  - req_ready_o[i] = (state != RELEASE) & ~arrived_q[i].
  - A core that has already arrived is back-pressured until it is released.
- IDLE:
  - On any accepted arrival, latch mask_q = barrier_mask_i.
  - Non-participating requesters (bit clear in mask) are released by themselves: rsp_valid_o pulses the next cycle, they never enter arrived_q, and gen_q does not change.
  - Participating accepted cores set arrived_q.
  - If arrived_q | accepted already covers mask_q, go to RELEASE; otherwise go to GATHER.
  - A mask of 0 means every requester is non-participating and the state stays IDLE.
- GATHER:
  - The mask is frozen; changes to barrier_mask_i are ignored until the next generation.
  - Accepted participating cores set arrived_q.
  - Accepted non-participating cores get the one-cycle-later self-release above.
  - When (arrived_q | accepted) & mask_q == mask_q, go to RELEASE in the next cycle.
  - tmo_cnt increments each GATHER cycle and saturates at its maximum.
  - If TimeoutCycles != 0 and tmo_cnt == TimeoutCycles-1 without completion, go to RELEASE with timeout flagged.
- RELEASE (exactly one cycle):
  - rsp_valid_o = arrived_q (plus any self-release due this cycle).
  - timeout_o = timeout flag.
  - gen_q++, wrapping modulo 2^CntWidth.
  - Clear arrived_q, tmo_cnt and the timeout flag; go to IDLE.
  - All req_ready_o are 0; requests are held off and accepted in the following IDLE cycle.
- Latency:
  - Last arrival accepted in cycle N -> rsp_valid_o in cycle N+1 -> req_ready_o high again in cycle N+2.
  - Single-participant mask: arrival in N, release in N+1.
- Simultaneous events:
  - All participants arriving in the same cycle completes the barrier in that cycle.
  - Completion and timeout in the same cycle count as a normal completion: timeout_o stays 0.
- stall_o = arrived_q; it drops in the RELEASE cycle.
- generation_o = gen_q.
- Requesters must hold req_valid_i until accepted. Holding req_valid_i after a release starts a new arrival in the next generation.

Test Plan:
1. NrCores=4, mask=4'b1111; cores 0,1,2 arrive in cycle 1 and core 3 in cycle 5 -> rsp_valid_o=4'b1111 in cycle 6 only; generation_o 0->1; stall_o=4'b0111 during cycles 2-5.
2. mask=4'b0101; core 1 requests in cycle 1 and core 0 in cycle 1 -> rsp_valid_o[1] in cycle 2 (self-release) with gen unchanged; core 2 arrives in cycle 4 -> rsp_valid_o=4'b0101 in cycle 5.
3. TimeoutCycles=8, mask=4'b1111, only core 0 arrives in cycle 1 -> timeout_o and rsp_valid_o=4'b0001 in cycle 10; generation_o=1.
4. Core 2 holds req_valid_i after arriving -> req_ready_o[2]=0 until release; second request accepted in the cycle after RELEASE; mask changed mid-GATHER has no effect.
5. rst_i asserted mid-GATHER with 3 of 4 arrived -> next cycle all outputs reset, no rsp pulse, req_ready_o=4'b1111.
6. CntWidth=4, run 16 barriers -> generation_o wraps 15->0.
